old_control: RTL and testbench

- Main control decoder for a single-issue MIPS-subset datapath.
- Decodes the 6-bit instruction opcode into datapath control strobes and a 2-bit ALUOp for the downstream ALU-control block.
- Outputs are registered: one pipeline stage between the fetch/IR stage and the execute/memory datapath.
- Unsupported opcodes decode to a safe all-zero (NOP) bundle and raise an illegal-opcode flag.

---
 rtl/old_control_if.sv | 24 ++
 rtl/old_control.sv | 67 ++++++
 tb/tb_old_control.sv | 74 +++++++
 3 files changed

// File: rtl/old_control_if.sv
// old_control_if: opcode/stall request and registered control strobes between the IR stage and the datapath
interface old_control_if;
  logic       stall;
  logic [5:0] opcode;
  logic       ALUSrc;
  logic [1:0] ALUOp;
  logic       RegDst;
  logic       MemWrite;
  logic       MemRead;
  logic       Beq;
  logic       Bne;
  logic       Jump;
  logic       MemToReg;
  logic       RegWrite;
  logic       Illegal;
  modport master (
    output stall, opcode,
    input  ALUSrc, ALUOp, RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite, Illegal
  );
  modport slave (
    input  stall, opcode,
    output ALUSrc, ALUOp, RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite, Illegal
  );
endinterface

// File: rtl/old_control.sv
// old_control: registered MIPS-subset main decoder; unknown opcodes give a NOP bundle plus Illegal
module old_control (
  input  logic          clk,
  input  logic          reset,
  old_control_if.slave  bus
);
  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_write;
    logic       mem_read;
    logic       beq;
    logic       bne;
    logic       jump;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;
  ctrl_t dec, ctrl_d, ctrl_q;
  always_comb begin
    dec = '0;
    case (bus.opcode)
      6'b000000: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
      end
      6'b100011: begin
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
      end
      6'b101011: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      6'b000100: begin
        dec.beq    = 1'b1;
        dec.alu_op = 2'b01;
      end
      6'b000101: begin
        dec.bne    = 1'b1;
        dec.alu_op = 2'b01;
      end
      6'b000010: dec.jump = 1'b1;
      default:   dec.illegal = 1'b1;
    endcase
    ctrl_d = bus.stall ? ctrl_q : dec;
  end
  always_ff @(posedge clk) begin
    if (reset) ctrl_q <= '0;
    else       ctrl_q <= ctrl_d;
  end
  assign bus.ALUSrc   = ctrl_q.alu_src;
  assign bus.ALUOp    = ctrl_q.alu_op;
  assign bus.RegDst   = ctrl_q.reg_dst;
  assign bus.MemWrite = ctrl_q.mem_write;
  assign bus.MemRead  = ctrl_q.mem_read;
  assign bus.Beq      = ctrl_q.beq;
  assign bus.Bne      = ctrl_q.bne;
  assign bus.Jump     = ctrl_q.jump;
  assign bus.MemToReg = ctrl_q.mem_to_reg;
  assign bus.RegWrite = ctrl_q.reg_write;
  assign bus.Illegal  = ctrl_q.illegal;
endmodule

// File: tb/tb_old_control.sv
// tb_old_control: directed scoreboard bench for the registered main decoder
module tb_old_control;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int passed = 0;
  logic [11:0] model_q = '0;
  logic [11:0] sb[$];
  old_control_if bus();
  old_control dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // Packing order: {ALUSrc, ALUOp[1:0], RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite, Illegal}
  function automatic logic [11:0] ref_dec(input logic [5:0] op);
    case (op)
      6'b000000: return 12'b0_10_1_0_0_0_0_0_0_1_0;
      6'b100011: return 12'b1_00_0_0_1_0_0_0_1_1_0;
      6'b101011: return 12'b1_00_0_1_0_0_0_0_0_0_0;
      6'b000100: return 12'b0_01_0_0_0_1_0_0_0_0_0;
      6'b000101: return 12'b0_01_0_0_0_0_1_0_0_0_0;
      6'b000010: return 12'b0_00_0_0_0_0_0_1_0_0_0;
      default:   return 12'b0_00_0_0_0_0_0_0_0_0_1;
    endcase
  endfunction
  function automatic logic [11:0] obs();
    return {bus.ALUSrc, bus.ALUOp, bus.RegDst, bus.MemWrite, bus.MemRead, bus.Beq,
            bus.Bne, bus.Jump, bus.MemToReg, bus.RegWrite, bus.Illegal};
  endfunction
  task automatic cyc(input string tag, input logic r, input logic s, input logic [5:0] op);
    logic [11:0] exp_v, got;
    logic ok;
    reset = r;
    bus.stall = s;
    bus.opcode = op;
    @(posedge clk);
    model_q = r ? 12'h000 : s ? model_q : ref_dec(op);
    sb.push_back(model_q);
    #1;
    exp_v = sb.pop_front();
    got = obs();
    checks++;
    assert (got === exp_v) passed++;
    else $error("FAIL %s op=%b got=%b exp=%b", tag, op, got, exp_v);
    ok = ((32'(bus.Beq) + 32'(bus.Bne) + 32'(bus.Jump)) <= 1) && !(bus.MemRead && bus.MemWrite)
         && !(bus.MemWrite && bus.RegWrite) && (bus.ALUOp !== 2'b11);
    checks++;
    assert (ok === 1'b1) passed++;
    else $error("FAIL %s_invariant op=%b got=%b exp=1", tag, op, ok);
  endtask
  initial begin
    cyc("reset0", 1'b1, 1'b0, 6'b100011);
    cyc("reset1", 1'b1, 1'b0, 6'b100011);
    cyc("lw_after_reset", 1'b0, 1'b0, 6'b100011);
    cyc("sweep_r", 1'b0, 1'b0, 6'b000000);
    cyc("sweep_lw", 1'b0, 1'b0, 6'b100011);
    cyc("sweep_sw", 1'b0, 1'b0, 6'b101011);
    cyc("sweep_beq", 1'b0, 1'b0, 6'b000100);
    cyc("sweep_bne", 1'b0, 1'b0, 6'b000101);
    cyc("sweep_j", 1'b0, 1'b0, 6'b000010);
    cyc("stall_load_beq", 1'b0, 1'b0, 6'b000100);
    for (int i = 0; i < 3; i++) cyc("stall_hold", 1'b0, 1'b1, 6'b000010);
    cyc("stall_release_j", 1'b0, 1'b0, 6'b000010);
    cyc("illegal_3f", 1'b0, 1'b0, 6'b111111);
    cyc("illegal_08", 1'b0, 1'b0, 6'b001000);
    cyc("illegal_clear", 1'b0, 1'b0, 6'b000000);
    cyc("rst_stall_load_lw", 1'b0, 1'b0, 6'b100011);
    cyc("rst_stall_hold", 1'b0, 1'b1, 6'b000000);
    cyc("rst_during_stall", 1'b1, 1'b1, 6'b100011);
    cyc("after_rst_stall", 1'b0, 1'b1, 6'b100011);
    for (int i = 0; i < 64; i++) cyc($sformatf("exh_%0d", i), 1'b0, 1'b0, i[5:0]);
    for (int i = 63; i >= 0; i--) cyc($sformatf("exh_rev_%0d", i), 1'b0, 1'b0, i[5:0]);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
